// File: rtl/fix2flt_pkg.sv
// Shared types and constants for the 8.8 fixed-point to IEEE-754 half
// converter.
//   state_t  : sequencer states
//   FIX_W    : fixed-point operand and half-float result width
//   EXP_W    : exponent field width
//   FRAC_W   : fraction field width
//   K_W      : normalisation shift counter width
//   EXP_TOP  : biased exponent when the operand MSB is already at bit 15
package fix2flt_pkg;

  localparam int FIX_W    = 16;
  localparam int EXP_W    = 5;
  localparam int FRAC_W   = 10;
  localparam int K_W      = 4;
  localparam int FLT_BIAS = 15;
  localparam int FIX_FRAC = 8;
  // A 1 at bit 15 of the magnitude is 2^(15-FIX_FRAC); bias it.
  localparam int EXP_TOP  = FLT_BIAS + (FIX_W - 1) - FIX_FRAC;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    NORM = 2'd1,
    PACK = 2'd2,
    DONE = 2'd3
  } state_t;

endpackage

// File: rtl/fix2flt_pack.sv
// Combinational half-float packer.
//   sign : result sign
//   k    : number of left shifts applied to normalise mag
//   mag  : normalised magnitude (mag[15] is the hidden one)
//   zero : operand was zero; forces +0.0
//   flt  : {sign, exp, frac} half-float pattern
module fix2flt_pack
  import fix2flt_pkg::*;
(
  input  logic             sign,
  input  logic [K_W-1:0]   k,
  input  logic [FIX_W-1:0] mag,
  input  logic             zero,
  output logic [FIX_W-1:0] flt
);

  logic [EXP_W-1:0] exp_f;

  assign exp_f = EXP_W'(EXP_TOP) - {1'b0, k};

  // Hidden one and the bits below the fraction are dropped: truncation,
  // no rounding.
  logic unused_bits;
  assign unused_bits = ^{mag[FIX_W-1], mag[FIX_W-FRAC_W-2:0]};

  always_comb begin
    flt = '0;
    if (!zero)
      flt = {sign, exp_f, mag[FIX_W-2 -: FRAC_W]};
  end

endmodule

// File: rtl/fix2flt_seq.sv
// Sequential 8.8 signed fixed-point to IEEE-754 half converter. Normalises
// one bit per cycle, so latency is k+2 edges (1 edge for a zero operand).
//   clk     : clock, rising edge
//   reset   : asynchronous, active-low
//   start   : request pulse, only looked at in IDLE
//   fix_in  : signed 8.8 operand, captured with start
//   flt_out : half result, held until the next conversion packs
//   busy    : high while not IDLE
//   done    : one-cycle completion pulse, flt_out valid with it
module fix2flt_seq
  import fix2flt_pkg::*;
(
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [FIX_W-1:0] fix_in,
  output logic [FIX_W-1:0] flt_out,
  output logic             busy,
  output logic             done
);

  state_t           state;
  logic             sign_q;
  logic             zero_q;
  logic [FIX_W-1:0] mag_q;
  logic [K_W-1:0]   k_q;
  logic [FIX_W-1:0] abs_in;
  logic [FIX_W-1:0] pack_flt;

  // 0x8000 negates to itself, which is exactly the 16-bit unsigned 128.0.
  assign abs_in = fix_in[FIX_W-1] ? (~fix_in + 1'b1) : fix_in;

  fix2flt_pack u_pack (
    .sign (sign_q),
    .k    (k_q),
    .mag  (mag_q),
    .zero (zero_q),
    .flt  (pack_flt)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state   <= IDLE;
      sign_q  <= 1'b0;
      zero_q  <= 1'b0;
      mag_q   <= '0;
      k_q     <= '0;
      flt_out <= '0;
      busy    <= 1'b0;
      done    <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            sign_q <= fix_in[FIX_W-1];
            mag_q  <= abs_in;
            k_q    <= '0;
            zero_q <= (abs_in == '0);
            state  <= (abs_in == '0) ? PACK : NORM;
            busy   <= 1'b1;
          end
        end
        NORM: begin
          if (mag_q[FIX_W-1]) begin
            state <= PACK;
          end else begin
            mag_q <= mag_q << 1;
            k_q   <= k_q + 1'b1;
          end
        end
        PACK: begin
          flt_out <= pack_flt;
          done    <= 1'b1;
          state   <= DONE;
        end
        DONE: begin
          // start is deliberately not examined here: no back-to-back queueing.
          done  <= 1'b0;
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: begin
          done  <= 1'b0;
          busy  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_fix2flt_seq.sv
module tb_fix2flt_seq;

  logic        clk;
  logic        reset;
  logic        start;
  logic [15:0] fix_in;
  logic [15:0] flt_out;
  logic        busy;
  logic        done;

  fix2flt_seq dut (
    .clk     (clk),
    .reset   (reset),
    .start   (start),
    .fix_in  (fix_in),
    .flt_out (flt_out),
    .busy    (busy),
    .done    (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [15:0] fix;
    logic [15:0] flt;
    int          lat;
  } vec_t;

  typedef struct {
    logic [15:0] flt;
    int          lat;
    int          samp;
  } sb_t;

  sb_t  sbq[$];
  sb_t  e;
  vec_t vt[10];
  int   n_chk    = 0;
  int   n_fail   = 0;
  int   edge_cnt = 0;
  int   done_cnt = 0;

  always @(posedge clk) edge_cnt++;

  // Truncating real-number reference: find e with 2^e <= |v| < 2^(e+1).
  function automatic logic [15:0] model(input logic [15:0] f, output int lat);
    real v, a, p;
    int  ex, fr;
    logic s;
    if (f == 16'h0000) begin
      lat = 1;
      return 16'h0000;
    end
    v  = $itor($signed(f)) / 256.0;
    s  = (v < 0.0);
    a  = s ? -v : v;
    p  = 1.0 / 256.0;
    ex = -8;
    while (p * 2.0 <= a) begin
      p  = p * 2.0;
      ex = ex + 1;
    end
    fr  = $rtoi((a / p - 1.0) * 1024.0);
    lat = 9 - ex;
    return {s, 5'(ex + 15), 10'(fr)};
  endfunction

  // Scoreboard consumer: every done must match the oldest pending request.
  always @(negedge clk) begin
    if (done) begin
      done_cnt++;
      n_chk++;
      if (sbq.size() == 0) begin
        n_fail++;
        $display("FAIL spurious_done: flt_out=%h with no conversion pending", flt_out);
      end else begin
        e = sbq.pop_front();
        if (flt_out !== e.flt) begin
          n_fail++;
          $display("FAIL flt_out: got %h, expected %h", flt_out, e.flt);
        end
        n_chk++;
        if (edge_cnt - e.samp != e.lat) begin
          n_fail++;
          $display("FAIL latency: done after edge %0d, expected edge %0d", edge_cnt - e.samp, e.lat);
        end
      end
    end
  end

  task automatic chk(input string name, input logic [15:0] got, input logic [15:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, got, exp);
    end
  endtask

  task automatic wait_done(input logic [15:0] f);
    int t;
    t = 0;
    while (!done && t < 40) begin
      @(negedge clk);
      t++;
    end
    n_chk++;
    if (!done) begin
      n_fail++;
      $display("FAIL timeout fix_in=%h: done got 0, expected 1 within 40 cycles", f);
      sbq.delete();
    end
  endtask

  task automatic do_conv(input logic [15:0] f, input logic [15:0] ef, input int el);
    @(negedge clk);
    start  = 1'b1;
    fix_in = f;
    sbq.push_back('{ef, el, edge_cnt + 1});
    @(negedge clk);
    start  = 1'b0;
    fix_in = 16'($urandom);   // must not disturb the captured operand
    wait_done(f);
    @(negedge clk);
  endtask

  initial begin
    int lat, n0;
    logic [15:0] ef;
    vt[0] = '{16'h0100, 16'h3C00, 9};
    vt[1] = '{16'h8000, 16'hD800, 2};
    vt[2] = '{16'h7FFF, 16'h57FF, 3};
    vt[3] = '{16'h0001, 16'h1C00, 17};
    vt[4] = '{16'h0000, 16'h0000, 1};
    vt[5] = '{16'hFEC0, 16'hBD00, 9};
    vt[6] = '{16'h0180, 16'h3E00, 9};
    vt[7] = '{16'h0200, 16'h4000, 8};
    vt[8] = '{16'hFFFF, 16'h9C00, 17};
    vt[9] = '{16'h8001, 16'hD7FF, 3};

    reset  = 1'b0;
    start  = 1'b0;
    fix_in = 16'h0000;
    #1;
    chk("reset_flt_out", flt_out, 16'h0000);
    chk("reset_busy", {15'd0, busy}, 16'h0000);
    chk("reset_done", {15'd0, done}, 16'h0000);
    repeat (3) @(posedge clk);
    #2 reset = 1'b1;

    // Directed table, including the latency extremes and -128.0.
    for (int i = 0; i < 10; i++)
      do_conv(vt[i].fix, vt[i].flt, vt[i].lat);

    // -0 is not a thing in fixed point; a zero after a negative must be +0.
    do_conv(16'hFFFF, 16'h9C00, 17);
    do_conv(16'h0000, 16'h0000, 1);

    // Re-pulse mid-conversion and hold start through DONE: both ignored.
    n0 = done_cnt;
    @(negedge clk);
    start  = 1'b1;
    fix_in = 16'h0100;
    sbq.push_back('{16'h3C00, 9, edge_cnt + 1});
    @(negedge clk);
    start = 1'b0;
    repeat (3) @(negedge clk);
    start  = 1'b1;
    fix_in = 16'h0200;
    @(negedge clk);
    start = 1'b0;
    wait_done(16'h0100);
    start  = 1'b1;
    fix_in = 16'h0200;
    @(posedge clk);
    #1 start = 1'b0;
    @(negedge clk);
    chk("repulse_busy_after_done", {15'd0, busy}, 16'h0000);
    repeat (3) @(negedge clk);
    chk("repulse_done_count", 16'(done_cnt - n0), 16'd1);
    chk("repulse_flt_out", flt_out, 16'h3C00);

    // Reset during NORM aborts without a done pulse.
    n0 = done_cnt;
    @(negedge clk);
    start  = 1'b1;
    fix_in = 16'h0100;
    sbq.push_back('{16'h3C00, 9, edge_cnt + 1});
    @(negedge clk);
    start = 1'b0;
    repeat (3) @(negedge clk);
    chk("abort_busy_before_reset", {15'd0, busy}, 16'h0001);
    #2 reset = 1'b0;
    #1;
    chk("abort_flt_out", flt_out, 16'h0000);
    chk("abort_busy", {15'd0, busy}, 16'h0000);
    chk("abort_done", {15'd0, done}, 16'h0000);
    repeat (20) @(negedge clk);
    chk("abort_no_done", 16'(done_cnt - n0), 16'd0);
    chk("abort_pending", 16'(sbq.size()), 16'd1);
    sbq.delete();
    @(posedge clk);
    #2 reset = 1'b1;
    do_conv(16'h0200, 16'h4000, 8);

    // Strided sweep plus random operands against the real-number model.
    for (int v = 0; v < 65536; v += 53) begin
      ef = model(16'(v), lat);
      do_conv(16'(v), ef, lat);
    end
    for (int i = 0; i < 300; i++) begin
      fix_in = 16'($urandom);
      ef = model(fix_in, lat);
      do_conv(fix_in, ef, lat);
    end

    repeat (5) @(negedge clk);
    chk("scoreboard_drained", 16'(sbq.size()), 16'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
